cv32e40p_obi_sram_resp: RTL and testbench



---
 rtl/cv32e40p_obi_pkg.sv | 16 +
 rtl/cv32e40p_obi_resp_pipe.sv | 32 +++
 rtl/cv32e40p_obi_sram_resp.sv | 128 ++++++++++++
 tb/tb_cv32e40p_obi_sram_resp.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_obi_pkg.sv
// Shared types and constants for the OBI SRAM responder.
package cv32e40p_obi_pkg;

    // Reset value of the optional grant-stall LFSR.
    localparam logic [15:0] OBI_LFSR_SEED = 16'hACE1;

    // Deepest response pipeline supported.
    localparam int unsigned OBI_MAX_LATENCY = 4;

    // One response-pipeline entry. rdata is 0 whenever valid is 0.
    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/cv32e40p_obi_resp_pipe.sv
// Fixed-depth delay line of OBI responses with asynchronous clear.
// An entry loaded at an edge appears on resp_o DEPTH-1 edges later.
module cv32e40p_obi_resp_pipe
    import cv32e40p_obi_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_resp_t resp_i,
    output obi_resp_t resp_o
);

    obi_resp_t stage_q [DEPTH];

    // Shift register: stage 0 takes the new entry, later stages follow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= resp_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign resp_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cv32e40p_obi_sram_resp.sv
// OBI SRAM responder: byte-enabled word memory behind a req/gnt address
// phase with fixed-latency, in-order rvalid responses.
// Optional macro CV32E40P_OBI_STALL_EN: LFSR-driven grant stalls (~25%).
//
// Handshake: a transaction is accepted at a rising edge where req_i and
// gnt_o are both 1; while req_i=1 and gnt_o=0 the requester holds req_i,
// we_i, be_i, addr_i and wdata_i stable. Each accepted transaction yields
// exactly one rvalid_o pulse RD_LATENCY cycles later; rvalid_o has no
// backpressure and responses return in acceptance order.
module cv32e40p_obi_sram_resp
    import cv32e40p_obi_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned RD_LATENCY      = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_mask;
    logic             accept;
    logic             unused_addr;
    obi_resp_t        pipe_in, pipe_out;

    // Word index; byte offset and upper bits are dropped so addresses alias.
    assign idx         = addr_i[IDX_W+1:2];
    assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

`ifdef CV32E40P_OBI_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11, shifting every cycle.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // LFSR state register, restarts from the fixed seed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= OBI_LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign stall_mask = (lfsr_q[1:0] == 2'b00);
`else
    assign stall_mask = 1'b0;
`endif

    assign gnt_o  = req_i && (cnt_q < MAX_OUT_C) && !stall_mask;
    assign accept = req_i && gnt_o;

    // Byte-enabled write into the array; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    // Build the response entry: full word for reads, zero for writes.
    always_comb begin
        pipe_in = '0;
        if (accept) begin
            pipe_in.valid = 1'b1;
            if (!we_i) pipe_in.rdata = mem_q[idx];
        end
    end

    cv32e40p_obi_resp_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .resp_i (pipe_in),
        .resp_o (pipe_out)
    );

    assign rvalid_o = pipe_out.valid;
    assign rdata_o  = pipe_out.valid ? pipe_out.rdata : 32'h0;

    // Outstanding count: up on accept, down on response, hold if both.
    always_comb begin
        cnt_d = cnt_q;
        case ({accept, pipe_out.valid})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Outstanding count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

`ifndef SYNTHESIS
    localparam bit PARAMS_OK = (MEM_WORDS >= 4) && ((MEM_WORDS & (MEM_WORDS - 1)) == 0)
                            && (RD_LATENCY >= 1) && (RD_LATENCY <= OBI_MAX_LATENCY)
                            && (MAX_OUTSTANDING >= 1) && (MAX_OUTSTANDING <= 8);

    param_legal: assert property (@(posedge clk_i) PARAMS_OK)
        else $error("illegal cv32e40p_obi_sram_resp parameters");

    req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> (req_i && $stable(we_i) && $stable(be_i)
                               && $stable(addr_i) && $stable(wdata_i)))
        else $error("request changed while waiting for grant");

    cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= MAX_OUT_C)
        else $error("outstanding count exceeded limit");
`endif

endmodule

// File: tb/tb_cv32e40p_obi_sram_resp.sv
// Self-checking bench for cv32e40p_obi_sram_resp (RD_LATENCY=3, MAX_OUTSTANDING=2).
// Build with CV32E40P_OBI_STALL_EN to exercise the grant-stall mode.
module tb_cv32e40p_obi_sram_resp;

    localparam int MEM_WORDS = 1024;
    localparam int RD_LAT    = 3;
    localparam int MAX_OUT   = 2;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    always #5 clk = ~clk;

    cv32e40p_obi_sram_resp #(
        .MEM_WORDS       (MEM_WORDS),
        .RD_LATENCY      (RD_LAT),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / reference model ----------------
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];      // expected rdata of each outstanding transaction
    int          due_q[$];      // cycle in which its rvalid must be visible
    logic [31:0] got_q[$];      // rdata of every observed response
    logic [31:0] ref_mem [MEM_WORDS];
    int          rvalid_cnt = 0;
    int          grant_cnt = 0;
    int          blocked_cnt = 0;
    int          stall_cnt = 0;
    int          last_rv_cyc = 0;
    int          last_acc_cyc = 0;
    logic [31:0] last_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: drive inputs, check outputs against the model, update the model.
    task automatic step(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, output logic acc);
        logic        exp_v;
        logic [31:0] exp_d;
        logic        allow;
        int          idx;
        @(negedge clk);
        req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
        #1;
        exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
        exp_d = exp_v ? exp_q[0] : 32'h0;
        check("rvalid", rvalid_o, exp_v);
        check("rdata", rdata_o, exp_d);
        allow = req && (due_q.size() < MAX_OUT);
`ifdef CV32E40P_OBI_STALL_EN
        if (gnt_o && !allow) check("gnt_forbidden", gnt_o, 1'b0);
        if (allow && !gnt_o) stall_cnt++;
`else
        check("gnt", gnt_o, allow);
`endif
        if (req && !gnt_o) blocked_cnt++;
        if (rvalid_o) begin
            rvalid_cnt++;
            last_rv_cyc = cyc;
            last_rdata  = rdata_o;
            got_q.push_back(rdata_o);
        end
        if (exp_v) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
        acc = req && gnt_o;
        if (acc) begin
            grant_cnt++;
            last_acc_cyc = cyc;
            idx = int'((addr >> 2) % MEM_WORDS);
            exp_q.push_back(we ? 32'h0 : ref_mem[idx]);
            due_q.push_back(cyc + RD_LAT);
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) ref_mem[idx][8*k +: 8] = wdata[8*k +: 8];
                end
            end
        end
    endtask

    task automatic idle();
        logic acc;
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc);
    endtask

    // Hold a request until it is granted (bounded).
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            step(1'b1, we, be, addr, wdata, acc);
            tries++;
        end
        if (!acc) check("issue_timeout", 32'(tries), 32'(0));
    endtask

    // Idle until every outstanding response has been seen (bounded).
    task automatic drain();
        int n;
        n = 0;
        while (due_q.size() > 0 && n < 64) begin
            idle();
            n++;
        end
        if (due_q.size() > 0) check("drain_timeout", 32'(due_q.size()), 32'(0));
        req_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
        exp_q.delete();
        due_q.delete();
        #1;
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_gnt_noreq", gnt_o, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] pre_val [32];

    initial begin
        int          rv0, gr0, blk0;
        logic        acc;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        int          idx;

        tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000};
        tbl[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h11223344, 32'h0000_0000};
        tbl[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABBCCDD, 32'h0000_0000};
        tbl[4]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0000_0000, 32'h11BB33DD};
        tbl[5]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h0000_0055, 32'h0000_0000};
        tbl[6]  = '{1'b0, 4'hF, 32'h0000_1004, 32'h0000_0000, 32'h0000_0055};
        tbl[7]  = '{1'b0, 4'hF, 32'h0000_1006, 32'h0000_0000, 32'h0000_0055};
        tbl[8]  = '{1'b1, 4'h0, 32'h0000_0020, 32'hFFFFFFFF, 32'h0000_0000};
        tbl[9]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'h11BB33DD};
        tbl[10] = '{1'b1, 4'h8, 32'h8000_0022, 32'h99000000, 32'h0000_0000};
        tbl[11] = '{1'b0, 4'h1, 32'h0000_0023, 32'h0000_0000, 32'h99BB33DD};

        // Reset state.
        do_reset();

        // Directed vectors: each issued alone, response awaited.
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata);
            drain();
            check($sformatf("tbl%0d_rdata", i), last_rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_latency", i), 32'(last_rv_cyc - last_acc_cyc), 32'(RD_LAT));
        end

        // Preload words 0..31 with known data.
        for (int i = 0; i < 32; i++) begin
            pre_val[i] = $urandom();
            issue(1'b1, 4'hF, 32'(i * 4), pre_val[i]);
        end
        drain();

        // Back-to-back reads: count limit forces grant gaps, data in order.
        got_q.delete();
        rv0  = rvalid_cnt;
        blk0 = blocked_cnt;
        for (int i = 0; i < 8; i++) issue(1'b0, 4'hF, 32'(i * 4), 32'h0);
        drain();
        check("b2b_gnt_drop", 32'(blocked_cnt > blk0), 32'(1));
        check("b2b_count", 32'(rvalid_cnt - rv0), 32'(8));
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check($sformatf("b2b_data%0d", i), got_q[i], pre_val[i]);
`ifndef CV32E40P_OBI_STALL_EN
        step(1'b1, 1'b0, 4'hF, 32'h0000_0008, 32'h0, acc);
        check("b2b_cnt_zero_gnt", acc, 1'b1);
        drain();
`endif

        // Reset with two reads in flight: those responses must vanish.
        issue(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        issue(1'b0, 4'hF, 32'h0000_0020, 32'h0);
        do_reset();
        rv0 = rvalid_cnt;
        repeat (6) idle();
        check("rst_no_rvalid", 32'(rvalid_cnt - rv0), 32'(0));
`ifndef CV32E40P_OBI_STALL_EN
        step(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0, acc);
        check("rst_gnt_immediate", acc, 1'b1);
`endif
        drain();

        // Random traffic against the reference model.
        rv0 = rvalid_cnt;
        gr0 = grant_cnt;
        for (int n = 0; n < 200; n++) begin
            we   = 1'($urandom_range(0, 1));
            be   = 4'($urandom_range(0, 15));
            idx  = $urandom_range(0, 31);
            addr = ($urandom() & 32'hFFFF_F000) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            issue(we, be, addr, $urandom());
            repeat ($urandom_range(0, 2)) idle();
        end
        drain();
        check("rand_rvalid_eq_grant", 32'(rvalid_cnt - rv0), 32'(grant_cnt - gr0));
`ifdef CV32E40P_OBI_STALL_EN
        check("stall_seen", 32'(stall_cnt > 0), 32'(1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
